sram_mm_arbiter: RTL and testbench

Two-port Avalon-MM arbiter that shares one sram_controller between two requesters, such as a host bridge and a DMA engine. Arbitration is round-robin. A granted command is locked until the downstream accepts it. Outstanding reads are tracked in a tag FIFO so each readdatavalid is returned to the requester that issued the read.

---
 rtl/sram_arb_pkg.sv | 8 +
 rtl/avalon_mm_if.sv | 15 +
 rtl/sram_arb_tag_fifo.sv | 43 ++++
 rtl/sram_mm_arbiter.sv | 70 +++++++
 tb/tb_sram_mm_arbiter.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared types and round-robin helper for the two-port SRAM arbiter
package sram_arb_pkg;
  localparam int NUM_PORTS = 2;
  typedef logic [0:0] port_id_t;
  function automatic port_id_t next_rr(port_id_t last, logic [NUM_PORTS-1:0] req);
    return (&req) ? ~last : port_id_t'(req[1]);
  endfunction
endpackage

// File: rtl/avalon_mm_if.sv
// avalon_mm_if: Avalon-MM command/response bundle with slave and master views
interface avalon_mm_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;
  logic              waitrequest;
  modport slave (input address, read, write, writedata, output readdata, readdatavalid, waitrequest);
  modport master (output address, read, write, writedata, input readdata, readdatavalid, waitrequest);
endinterface

// File: rtl/sram_arb_tag_fifo.sv
// sram_arb_tag_fifo: in-order FIFO of requester ids for reads still awaiting data
module sram_arb_tag_fifo
  import sram_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     push_i,
  input  port_id_t push_id_i,
  input  logic     pop_i,
  output port_id_t head_id_o,
  output logic     full_o,
  output logic     empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  port_id_t        mem_q [DEPTH];
  logic [AW-1:0]   wp_q, rp_q;
  logic [CW-1:0]   cnt_q;
  logic            do_push, do_pop;
  assign full_o    = cnt_q == CW'(DEPTH);
  assign empty_o   = cnt_q == '0;
  assign do_push   = push_i & !full_o;
  assign do_pop    = pop_i & !empty_o;
  assign head_id_o = mem_q[rp_q];
  // Pointers and occupancy; a pop on an empty FIFO is dropped so count cannot underflow
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wp_q <= wp_q + AW'(1);
      if (do_pop) rp_q <= rp_q + AW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end
  // Storage needs no reset: entries are only read while counted as occupied
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wp_q] <= push_id_i;
  end
endmodule

// File: rtl/sram_mm_arbiter.sv
// sram_mm_arbiter: two-port Avalon-MM arbiter sharing one SRAM controller (define SRAM_ARB_FIXED_PRIO_EN for fixed port-0 priority instead of round-robin)
module sram_mm_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W      = 20,
  parameter int DATA_W      = 16,
  parameter int MAX_PENDING = 4
) (
  input logic         clk_i,
  input logic         rst_i,
  avalon_mm_if.slave  s0_if,
  avalon_mm_if.slave  s1_if,
  avalon_mm_if.master m_if
);
  logic [1:0]        rd, wr, elig;
  logic              full, empty, gnt_v, cmd, acc, lock_q;
  port_id_t          sel, gnt_id, lock_id_q, head_id;
  logic [ADDR_W-1:0] addr_sel;
  logic [DATA_W-1:0] wdata_sel;
  assign rd   = {s1_if.read, s0_if.read};
  assign wr   = {s1_if.write, s0_if.write};
  assign elig = wr | (rd & {2{!full}});
`ifdef SRAM_ARB_FIXED_PRIO_EN
  assign sel = port_id_t'(!elig[0]);
`else
  port_id_t last_q;
  assign sel = next_rr(last_q, elig);
  // Remember the last accepted port so ties alternate; port 1 after reset lets port 0 win first
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) last_q <= 1'b1;
    else if (acc) last_q <= gnt_id;
  end
`endif
  assign gnt_v     = !rst_i & (lock_q | (|elig));
  assign gnt_id    = lock_q ? lock_id_q : sel;
  assign addr_sel  = gnt_id[0] ? s1_if.address : s0_if.address;
  assign wdata_sel = gnt_id[0] ? s1_if.writedata : s0_if.writedata;
  assign m_if.address   = gnt_v ? addr_sel : '0;
  assign m_if.writedata = gnt_v ? wdata_sel : '0;
  assign m_if.read      = gnt_v & rd[gnt_id];
  assign m_if.write     = gnt_v & wr[gnt_id];
  assign cmd = m_if.read | m_if.write;
  assign acc = cmd & !m_if.waitrequest;
  assign s0_if.waitrequest   = !(gnt_v & (gnt_id == 1'b0)) | m_if.waitrequest;
  assign s1_if.waitrequest   = !(gnt_v & (gnt_id == 1'b1)) | m_if.waitrequest;
  assign s0_if.readdata      = m_if.readdata;
  assign s1_if.readdata      = m_if.readdata;
  assign s0_if.readdatavalid = m_if.readdatavalid & !empty & (head_id == 1'b0);
  assign s1_if.readdatavalid = m_if.readdatavalid & !empty & (head_id == 1'b1);
  // Hold the grant on a stalled command until the controller takes it
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lock_q    <= 1'b0;
      lock_id_q <= '0;
    end else begin
      lock_q    <= cmd & m_if.waitrequest;
      lock_id_q <= gnt_id;
    end
  end
  sram_arb_tag_fifo #(.DEPTH(MAX_PENDING)) u_tags (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push_i    (acc & m_if.read),
    .push_id_i (gnt_id),
    .pop_i     (m_if.readdatavalid),
    .head_id_o (head_id),
    .full_o    (full),
    .empty_o   (empty)
  );
endmodule

// File: tb/tb_sram_mm_arbiter.sv
// tb_sram_mm_arbiter: directed checks of grant, lock, read routing, full and reset behaviour
module tb_sram_mm_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   passed = 0;
  int   failed = 0;
  int   total = 0;
  avalon_mm_if #(.ADDR_W(20), .DATA_W(16)) s0 ();
  avalon_mm_if #(.ADDR_W(20), .DATA_W(16)) s1 ();
  avalon_mm_if #(.ADDR_W(20), .DATA_W(16)) m ();
  sram_mm_arbiter #(.ADDR_W(20), .DATA_W(16), .MAX_PENDING(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .s0_if (s0),
    .s1_if (s1),
    .m_if  (m)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic req(input logic r0, input logic w0, input logic [19:0] a0,
                     input logic r1, input logic w1, input logic [19:0] a1);
    s0.read = r0; s0.write = w0; s0.address = a0; s0.writedata = 16'hA5A5;
    s1.read = r1; s1.write = w1; s1.address = a1; s1.writedata = 16'h5A5A;
  endtask
  task automatic mem(input logic wt, input logic rv, input logic [15:0] rdat);
    m.waitrequest = wt; m.readdatavalid = rv; m.readdata = rdat;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req(0, 0, 0, 0, 0, 0);
    mem(0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask
  initial begin
    // Reset state, with a request and a ready controller present
    req(0, 1, 20'h00010, 0, 0, 0);
    mem(0, 0, 0);
    #1;
    chk("rst_m_write", m.write, 0);
    chk("rst_m_read", m.read, 0);
    chk("rst_s0_wait", s0.waitrequest, 1);
    chk("rst_s1_wait", s1.waitrequest, 1);
    chk("rst_s0_rdv", s0.readdatavalid, 0);
    // Single-port write passes straight through
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("single_write", m.write, 1);
    chk("single_addr", m.address, 32'h10);
    chk("single_wdata", m.writedata, 32'hA5A5);
    chk("single_s0_wait", s0.waitrequest, 0);
    chk("single_s1_wait", s1.waitrequest, 1);
    // Contention: both write every cycle
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      req(0, 1, 20'h00100, 0, 1, 20'h00200);
      #1;
`ifdef SRAM_ARB_FIXED_PRIO_EN
      chk("cont_addr", m.address, 32'h100);
      chk("cont_s1_wait", s1.waitrequest, 1);
`else
      chk("cont_addr", m.address, (i % 2 == 0) ? 32'h100 : 32'h200);
      chk("cont_s0_wait", s0.waitrequest, (i % 2 == 0) ? 0 : 1);
`endif
    end
    // Lock: s1 stalled for 3 cycles while s0 competes
    @(negedge clk);
    req(0, 0, 0, 0, 1, 20'h00222);
    mem(1, 0, 0);
    #1;
    chk("lock_c0_addr", m.address, 32'h222);
    chk("lock_c0_s1_wait", s1.waitrequest, 1);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      req(0, 1, 20'h00100, 0, 1, 20'h00222);
      mem((j < 2) ? 1'b1 : 1'b0, 0, 0);
      #1;
      chk("lock_hold_addr", m.address, 32'h222);
      chk("lock_hold_s0_wait", s0.waitrequest, 1);
    end
    @(negedge clk);
    mem(0, 0, 0);
    #1;
    chk("lock_after_addr", m.address, 32'h100);
    chk("lock_after_s0_wait", s0.waitrequest, 0);
    // Read routing: s0, s1, s0 with data two cycles later
    do_reset();
    @(negedge clk);
    req(1, 0, 20'h1, 0, 0, 0);
    #1;
    chk("rd0_addr", m.address, 32'h1);
    chk("rd0_read", m.read, 1);
    @(negedge clk);
    req(0, 0, 0, 1, 0, 20'h2);
    #1;
    chk("rd1_addr", m.address, 32'h2);
    @(negedge clk);
    req(1, 0, 20'h3, 0, 0, 0);
    mem(0, 1, 16'h1111);
    #1;
    chk("rd2_addr", m.address, 32'h3);
    chk("rv0_s0", s0.readdatavalid, 1);
    chk("rv0_s1", s1.readdatavalid, 0);
    chk("rv0_data", s0.readdata, 32'h1111);
    @(negedge clk);
    req(0, 0, 0, 0, 0, 0);
    mem(0, 1, 16'h2222);
    #1;
    chk("rv1_s0", s0.readdatavalid, 0);
    chk("rv1_s1", s1.readdatavalid, 1);
    chk("rv1_data", s1.readdata, 32'h2222);
    @(negedge clk);
    mem(0, 1, 16'h3333);
    #1;
    chk("rv2_s0", s0.readdatavalid, 1);
    chk("rv2_s1", s1.readdatavalid, 0);
    chk("rv2_data", s0.readdata, 32'h3333);
    @(negedge clk);
    mem(0, 1, 16'h4444);
    #1;
    chk("rv_empty_s0", s0.readdatavalid, 0);
    chk("rv_empty_s1", s1.readdatavalid, 0);
    // Full: four reads outstanding blocks further reads but not writes
    do_reset();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      req(1, 0, 20'h10 + 20'(k), 0, 0, 0);
      mem(0, 0, 0);
      #1;
      chk("fill_addr", m.address, 32'h10 + k);
    end
    @(negedge clk);
    req(1, 0, 20'h50, 0, 1, 20'h60);
    #1;
    chk("full_addr", m.address, 32'h60);
    chk("full_write", m.write, 1);
    chk("full_read", m.read, 0);
    chk("full_s0_wait", s0.waitrequest, 1);
    @(negedge clk);
    req(1, 0, 20'h50, 0, 0, 0);
    mem(0, 1, 16'hBEEF);
    #1;
    chk("full_pop_s0_wait", s0.waitrequest, 1);
    chk("full_pop_read", m.read, 0);
    chk("full_pop_rdv", s0.readdatavalid, 1);
    @(negedge clk);
    mem(0, 0, 0);
    #1;
    chk("unfull_read", m.read, 1);
    chk("unfull_addr", m.address, 32'h50);
    chk("unfull_s0_wait", s0.waitrequest, 0);
    // Reset with two reads in flight
    do_reset();
    @(negedge clk);
    req(1, 0, 20'h70, 0, 0, 0);
    @(negedge clk);
    req(1, 0, 20'h71, 0, 0, 0);
    @(negedge clk);
    req(1, 0, 20'h72, 0, 0, 0);
    rst = 1'b1;
    #1;
    chk("midrst_read", m.read, 0);
    chk("midrst_s0_wait", s0.waitrequest, 1);
    @(negedge clk);
    rst = 1'b0;
    req(0, 0, 0, 0, 0, 0);
    mem(0, 1, 16'hDEAD);
    #1;
    chk("postrst_s0_rdv", s0.readdatavalid, 0);
    chk("postrst_s1_rdv", s1.readdatavalid, 0);
    @(negedge clk);
    req(0, 0, 0, 1, 0, 20'h73);
    mem(0, 0, 0);
    #1;
    chk("postrst_rd_addr", m.address, 32'h73);
    @(negedge clk);
    req(0, 0, 0, 0, 0, 0);
    mem(0, 1, 16'h7373);
    #1;
    chk("postrst_rv_s1", s1.readdatavalid, 1);
    chk("postrst_rv_s0", s0.readdatavalid, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
